// File: rtl/logic_result_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package : logic_result_stage_pkg
//  Purpose : Opcode constants shared by the logic unit, the decoder and the
//            result stage, plus the occupancy-state encoding of the stage.
//  Contents: OP_AND/OP_OR/OP_XOR/OP_NOR, is_logic_op(), occ_state_t
//  Revision: 1.0 - initial release
// ============================================================================
package logic_result_stage_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_AND = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_NOR = 4'b0111;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_ONE   = 2'd1,   // main entry only
        ST_FULL  = 2'd2    // main + skid entry
    } occ_state_t;

    // True for the four opcodes the logic unit actually implements.
    function automatic logic is_logic_op(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_AND) || (opcode == OP_OR) ||
               (opcode == OP_XOR) || (opcode == OP_NOR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_result_stage_result_flags.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : result_flags
//  Purpose : Combinational zero / negative / illegal-opcode flags for one
//            logic-unit result.
//  Ports   : result_i   [WIDTH-1:0]  logic unit output
//            opcode_i   [3:0]        opcode that produced result_i
//            zero_o                  result_i == 0
//            neg_o                   result_i MSB
//            illegal_o               opcode_i is not an implemented logic op
//  Revision: 1.0 - initial release
// ============================================================================
module result_flags
    import logic_result_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    result_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                zero_o,
    output logic                neg_o,
    output logic                illegal_o
);

    assign zero_o    = (result_i == '0);
    assign neg_o     = result_i[WIDTH-1];
    assign illegal_o = !is_logic_op(opcode_i);

endmodule

`default_nettype wire

// File: rtl/logic_result_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : logic_result_stage
//  Purpose : Registered result stage behind the 32-bit logic unit. Captures
//            result + derived flags, and hands them to writeback over a
//            valid/ready handshake through a 2-entry skid buffer so that
//            in_ready comes straight from a flop.
//  Ports   : clk, reset (async, active-high)
//            in_valid / in_ready / in_result / in_opcode   issue side
//            out_valid / out_ready / out_data              writeback side
//            out_zero / out_neg / out_illegal              flags of out_data
//            illegal_cnt                                   saturating count of
//                                                          accepted illegal ops
//  Revision: 1.0 - initial release
// ============================================================================
module logic_result_stage
    import logic_result_stage_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_result,
    input  logic [OPCODE_W-1:0]  in_opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Flags are derived once, on the input side, and stored with the entry
    // ------------------------------------------------------------------
    logic w_zero;
    logic w_neg;
    logic w_illegal;

    result_flags #(
        .WIDTH (WIDTH)
    ) u_result_flags (
        .result_i  (in_result),
        .opcode_i  (in_opcode),
        .zero_o    (w_zero),
        .neg_o     (w_neg),
        .illegal_o (w_illegal)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    occ_state_t       state_q;
    logic             in_ready_q;
    logic             main_valid_q;
    logic [WIDTH-1:0] main_data_q;
    logic             main_zero_q;
    logic             main_neg_q;
    logic             main_ill_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_zero_q;
    logic             skid_neg_q;
    logic             skid_ill_q;

    logic w_accept;
    logic w_drain;

    assign w_accept = in_valid && in_ready_q;
    assign w_drain  = main_valid_q && out_ready;

    // Occupancy FSM. in_ready_q is updated alongside the state so it always
    // equals "skid empty" without any combinational path from out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_zero_q  <= 1'b0;
            main_neg_q   <= 1'b0;
            main_ill_q   <= 1'b0;
            skid_data_q  <= '0;
            skid_zero_q  <= 1'b0;
            skid_neg_q   <= 1'b0;
            skid_ill_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        main_valid_q <= 1'b1;
                        main_data_q  <= in_result;
                        main_zero_q  <= w_zero;
                        main_neg_q   <= w_neg;
                        main_ill_q   <= w_illegal;
                        state_q      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        // Main is leaving this cycle, so the new entry replaces it.
                        main_data_q <= in_result;
                        main_zero_q <= w_zero;
                        main_neg_q  <= w_neg;
                        main_ill_q  <= w_illegal;
                    end else if (w_accept) begin
                        skid_data_q <= in_result;
                        skid_zero_q <= w_zero;
                        skid_neg_q  <= w_neg;
                        skid_ill_q  <= w_illegal;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_FULL;
                    end else if (w_drain) begin
                        // Flags read as 0 whenever nothing is presented.
                        main_valid_q <= 1'b0;
                        main_zero_q  <= 1'b0;
                        main_neg_q   <= 1'b0;
                        main_ill_q   <= 1'b0;
                        state_q      <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No accept possible here: in_ready_q is low.
                    if (w_drain) begin
                        main_data_q <= skid_data_q;
                        main_zero_q <= skid_zero_q;
                        main_neg_q  <= skid_neg_q;
                        main_ill_q  <= skid_ill_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                default: begin
                    state_q      <= ST_EMPTY;
                    in_ready_q   <= 1'b1;
                    main_valid_q <= 1'b0;
                    main_zero_q  <= 1'b0;
                    main_neg_q   <= 1'b0;
                    main_ill_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating illegal-opcode counter, counted at accept time
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (w_accept && w_illegal && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_data    = main_data_q;
    assign out_zero    = main_zero_q;
    assign out_neg     = main_neg_q;
    assign out_illegal = main_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

`default_nettype wire
